universal_shift_register: RTL and testbench
===========================================

# universal_shift_register

Parametrised universal shift register: the general-purpose successor to the fixed 4-bit serial-in/serial-out chain. It adds hold, bidirectional shift, rotate and parallel load, selected per cycle by a mode input. A frame counter reports when WIDTH bits have been shifted since the last load or reset. Serialisers, deserialisers and LFSR-style test logic instantiate it directly.

## Interface
- WIDTH, 4: register width in bits; legal range WIDTH >= 2.
- RESET_VALUE, {WIDTH{1'b0}}: value loaded into q on reset.
- CW, $clog2(WIDTH+1): width of count (derived, not overridden).

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  3  operation select, sampled every rising edge.
- sin  in  1  serial input bit for shift modes.
- din  in  WIDTH  parallel load data.
- q  out  WIDTH  register contents (registered).
- sout_r  out  1  q[0]; the bit lost on the next right shift.
- sout_l  out  1  q[WIDTH-1]; the bit lost on the next left shift.
- count  out  CW  shifts/rotates since last load or reset, saturating at WIDTH.
- frame_done  out  1  one-cycle pulse when count reaches WIDTH.

## Operation
- Reset: one clk, one reset, synchronous and active-high. With reset high at an edge: q <= RESET_VALUE, count <= 0, frame_done <= 0. Reset overrides mode.
- mode 000, hold: q unchanged, count unchanged.
- mode 001, shift right: q <= {sin, q[WIDTH-1:1]}. sin enters the MSB; the LSB is discarded.
- mode 010, shift left: q <= {q[WIDTH-2:0], sin}. sin enters the LSB; the MSB is discarded.
- mode 011, rotate right: q <= {q[0], q[WIDTH-1:1]}. sin is ignored.
- mode 100, rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}. sin is ignored.
- mode 101, parallel load: q <= din, count <= 0.
- mode 110 and 111: reserved. They behave exactly as hold.
- Counter: modes 001–100 increment count when count < WIDTH. At count == WIDTH it holds at WIDTH; it never wraps.
- frame_done:
  - Registered. It is 1 for exactly the cycle after the edge at which count goes from WIDTH-1 to WIDTH.
  - It is 0 in all other cycles.
  - Further shifts at saturation do not re-pulse.
  - Only a load or a reset re-arms the pulse.
- Serial outputs are combinational taps of registered q. They carry no extra state.

## Timing
- Latency: q, count and frame_done reflect the mode/sin/din sampled at edge N immediately after edge N (1 cycle).
- sout_r and sout_l change on the same edge as q.
- Back-to-back modes are legal every cycle. No handshake and no idle cycle are required between a load and a shift, or between shift directions.
- A load in the cycle after count saturates clears count. frame_done still pulses for that cycle if it was already scheduled.
- Mixed directions all count toward the same frame. For example, 2 right shifts plus 2 rotate-lefts give count = WIDTH = 4.
- Reset mid-frame: count returns to 0 and no frame_done is produced for the aborted frame.

## Test plan
- Reset then right-shift, WIDTH=4:
  - Stimulus: reset 1 cycle; mode=001 with sin 1,1,0,1.
  - q: 0000 → 1000 → 1100 → 0110 → 1011.
  - count: 1,2,3,4.
  - frame_done: high only in the cycle after the 4th edge.
- Saturation:
  - Stimulus: continue mode=001 with sin=0 for 2 more edges.
  - q: 0101, 0010.
  - count: stays at 4.
  - frame_done: stays 0.
- Load then rotate-right:
  - Stimulus: mode=101 with din=1001; then mode=011 for 4 edges.
  - q: 1001 → 1100 → 0110 → 0011 → 1001.
  - count: 0 after the load, then 4.
  - frame_done: one pulse.
- Left shift and sout_l:
  - Stimulus: load 0001; then mode=010 with sin=0 for 4 edges.
  - q: 0010, 0100, 1000, 0000.
  - sout_l: 0,0,0,1,0 across the five states.
- Hold, reserved modes and reset priority:
  - Stimulus: load 1010; apply mode 000, 110 and 111 for 1 edge each; then mode=001 with reset=1.
  - q: stays 1010 through the three hold-type edges; becomes RESET_VALUE after the reset edge.
  - count: 0.
  - frame_done: 0.
- Reset mid-frame:
  - Stimulus: load; 2 shifts; reset for 1 cycle; 4 shifts.
  - count: 2 → 0 → 4.
  - frame_done: exactly one pulse, after the 4th post-reset shift.

Source files
------------

// File: rtl/universal_shift_register_if.sv
// Bus bundle for the universal shift register: mode/serial/parallel inputs
// and the registered contents, serial taps, frame counter and frame pulse.
interface universal_shift_register_if #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic [2:0]       mode;
    logic             sin;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic [CW-1:0]    count;
    logic             frame_done;

    modport master (
        output mode, sin, din,
        input  q, sout_r, sout_l, count, frame_done
    );

    modport slave (
        input  mode, sin, din,
        output q, sout_r, sout_l, count, frame_done
    );
endinterface

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift/rotate in both directions and parallel
// load per cycle, with a saturating frame counter and a one-shot frame pulse.
module universal_shift_register #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    localparam int              CW          = $clog2(WIDTH + 1)
) (
    input logic                           clk,
    input logic                           reset,
    universal_shift_register_if.slave     bus
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_ROR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_LOAD = 3'b101
    } mode_e;

    localparam logic [CW-1:0] COUNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] reg_q, reg_d;
    logic [CW-1:0]    count_q, count_d;
    logic             frame_done_q, frame_done_d;
    logic             advance;

    always_comb begin
        reg_d        = reg_q;
        count_d      = count_q;
        frame_done_d = 1'b0;
        advance      = 1'b0;

        case (bus.mode)
            MODE_HOLD: ;
            MODE_SHR: begin
                reg_d   = {bus.sin, reg_q[WIDTH-1:1]};
                advance = 1'b1;
            end
            MODE_SHL: begin
                reg_d   = {reg_q[WIDTH-2:0], bus.sin};
                advance = 1'b1;
            end
            MODE_ROR: begin
                reg_d   = {reg_q[0], reg_q[WIDTH-1:1]};
                advance = 1'b1;
            end
            MODE_ROL: begin
                reg_d   = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
                advance = 1'b1;
            end
            MODE_LOAD: begin
                reg_d   = bus.din;
                count_d = '0;
            end
            default: ;
        endcase

        // Counter saturates at WIDTH; the pulse fires only on the WIDTH-1 -> WIDTH step.
        if (advance && (count_q != COUNT_FULL)) begin
            count_d      = count_q + 1'b1;
            frame_done_d = (count_q == COUNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_q        <= RESET_VALUE;
            count_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            reg_q        <= reg_d;
            count_q      <= count_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.q          = reg_q;
    assign bus.sout_r     = reg_q[0];
    assign bus.sout_l     = reg_q[WIDTH-1];
    assign bus.count      = count_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Testbench for universal_shift_register (WIDTH=4): directed scenarios with
// fixed expectations plus randomized traffic against an arithmetic model.
module tb_universal_shift_register;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;
    localparam logic [W-1:0] RV = 4'b0000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // reference model state
    int mq = 0;
    int mc = 0;
    int mf = 0;

    always #5 clk = ~clk;

    universal_shift_register_if #(.WIDTH(W)) bus ();

    universal_shift_register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Drive one cycle of inputs, let the edge pass, advance the model.
    task automatic step(input int r, input int m, input int s, input int d);
        int nq;
        reset    = r[0];
        bus.mode = m[2:0];
        bus.sin  = s[0];
        bus.din  = d[W-1:0];
        @(posedge clk);
        #1;
        if (r != 0) begin
            mq = int'(RV); mc = 0; mf = 0;
        end else begin
            nq = mq;
            mf = 0;
            case (m)
                1: nq = (mq >> 1) | ((s & 1) << (W - 1));
                2: nq = ((mq << 1) | (s & 1)) & MASK;
                3: nq = (mq >> 1) | ((mq & 1) << (W - 1));
                4: nq = ((mq << 1) & MASK) | (mq >> (W - 1));
                5: begin nq = d & MASK; mc = 0; end
                default: nq = mq;
            endcase
            if (m >= 1 && m <= 4 && mc < W) begin
                mc = mc + 1;
                if (mc == W) mf = 1;
            end
            mq = nq;
        end
    endtask

    task automatic test_reset;
        step(1, 0, 0, 0);
        checks++;
        if (bus.q !== RV) begin errors++; $display("FAIL reset_q got=%b want=%b", bus.q, RV); end
        checks++;
        if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", bus.count); end
        checks++;
        if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got=%b want=0", bus.frame_done); end
    endtask

    task automatic test_shift_right;
        int sins[4] = '{1, 1, 0, 1};
        int eq[4]   = '{4'b1000, 4'b1100, 4'b0110, 4'b1011};
        int efd[4]  = '{0, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            step(0, 1, sins[i], 0);
            checks++;
            if (bus.q !== eq[i][W-1:0]) begin errors++; $display("FAIL shr_q[%0d] got=%b want=%b", i, bus.q, eq[i][W-1:0]); end
            checks++;
            if (bus.count !== 3'(i + 1)) begin errors++; $display("FAIL shr_count[%0d] got=%0d want=%0d", i, bus.count, i + 1); end
            checks++;
            if (bus.frame_done !== efd[i][0]) begin errors++; $display("FAIL shr_fd[%0d] got=%b want=%b", i, bus.frame_done, efd[i][0]); end
            checks++;
            if (bus.sout_r !== eq[i][0]) begin errors++; $display("FAIL shr_sout_r[%0d] got=%b want=%b", i, bus.sout_r, eq[i][0]); end
        end
    endtask

    task automatic test_saturation;
        int eq[2] = '{4'b0101, 4'b0010};
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 0, 0);
            checks++;
            if (bus.q !== eq[i][W-1:0]) begin errors++; $display("FAIL sat_q[%0d] got=%b want=%b", i, bus.q, eq[i][W-1:0]); end
            checks++;
            if (bus.count !== 3'd4) begin errors++; $display("FAIL sat_count[%0d] got=%0d want=4", i, bus.count); end
            checks++;
            if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL sat_fd[%0d] got=%b want=0", i, bus.frame_done); end
        end
    endtask

    task automatic test_load_rotate;
        int eq[4]  = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
        int pulses = 0;
        step(0, 5, 0, 4'b1001);
        checks++;
        if (bus.q !== 4'b1001 || bus.count !== 3'd0) begin
            errors++; $display("FAIL load_q_count got=%b/%0d want=1001/0", bus.q, bus.count);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 3, 1, 0);
            if (bus.frame_done === 1'b1) pulses++;
            checks++;
            if (bus.q !== eq[i][W-1:0]) begin errors++; $display("FAIL ror_q[%0d] got=%b want=%b", i, bus.q, eq[i][W-1:0]); end
        end
        checks++;
        if (bus.count !== 3'd4) begin errors++; $display("FAIL ror_count got=%0d want=4", bus.count); end
        checks++;
        if (pulses != 1 || bus.frame_done !== 1'b1) begin
            errors++; $display("FAIL ror_fd pulses=%0d last=%b want=1/1", pulses, bus.frame_done);
        end
    endtask

    task automatic test_shift_left;
        int eq[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0000};
        int el[4] = '{0, 0, 1, 0};
        step(0, 5, 0, 4'b0001);
        checks++;
        if (bus.sout_l !== 1'b0 || bus.sout_r !== 1'b1) begin
            errors++; $display("FAIL shl_taps_after_load got=%b%b want=01", bus.sout_l, bus.sout_r);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 2, 0, 0);
            checks++;
            if (bus.q !== eq[i][W-1:0]) begin errors++; $display("FAIL shl_q[%0d] got=%b want=%b", i, bus.q, eq[i][W-1:0]); end
            checks++;
            if (bus.sout_l !== el[i][0]) begin errors++; $display("FAIL shl_sout_l[%0d] got=%b want=%b", i, bus.sout_l, el[i][0]); end
        end
        checks++;
        if (bus.count !== 3'd4 || bus.frame_done !== 1'b1) begin
            errors++; $display("FAIL shl_frame got=%0d/%b want=4/1", bus.count, bus.frame_done);
        end
    endtask

    task automatic test_hold_reserved;
        int hm[3] = '{0, 6, 7};
        step(0, 5, 1, 4'b1010);
        for (int i = 0; i < 3; i++) begin
            step(0, hm[i], 1, 4'b0101);
            checks++;
            if (bus.q !== 4'b1010 || bus.count !== 3'd0) begin
                errors++; $display("FAIL hold_mode%0d got=%b/%0d want=1010/0", hm[i], bus.q, bus.count);
            end
        end
        step(1, 1, 1, 0);
        checks++;
        if (bus.q !== RV || bus.count !== 3'd0 || bus.frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_priority got=%b/%0d/%b want=%b/0/0", bus.q, bus.count, bus.frame_done, RV);
        end
    endtask

    task automatic test_reset_mid_frame;
        int pulses = 0;
        step(0, 5, 0, 4'b0110);
        step(0, 1, 1, 0);
        step(0, 2, 0, 0);
        checks++;
        if (bus.count !== 3'd2) begin errors++; $display("FAIL midreset_pre got=%0d want=2", bus.count); end
        step(1, 1, 0, 0);
        checks++;
        if (bus.count !== 3'd0 || bus.frame_done !== 1'b0) begin
            errors++; $display("FAIL midreset_clear got=%0d/%b want=0/0", bus.count, bus.frame_done);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, (i < 2) ? 1 : 4, 1, 0);
            if (bus.frame_done === 1'b1) pulses++;
            checks++;
            if (bus.frame_done !== ((i == 3) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL midreset_fd[%0d] got=%b want=%b", i, bus.frame_done, (i == 3));
            end
        end
        checks++;
        if (bus.count !== 3'd4 || pulses != 1) begin
            errors++; $display("FAIL midreset_post got=%0d pulses=%0d want=4/1", bus.count, pulses);
        end
    endtask

    task automatic test_back_to_back;
        int r, m;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 39) == 0) ? 1 : 0;
            m = ($urandom_range(0, 5) == 0) ? 5 : int'($urandom_range(0, 7));
            step(r, m, int'($urandom_range(0, 1)), int'($urandom_range(0, MASK)));
            checks++;
            if (bus.q !== mq[W-1:0] || bus.count !== mc[2:0] || bus.frame_done !== mf[0] ||
                bus.sout_r !== mq[0] || bus.sout_l !== mq[W-1]) begin
                errors++;
                $display("FAIL rand[%0d] mode=%0d rst=%0d got q=%b c=%0d fd=%b sr=%b sl=%b want q=%b c=%0d fd=%0d",
                         i, m, r, bus.q, bus.count, bus.frame_done, bus.sout_r, bus.sout_l,
                         mq[W-1:0], mc, mf);
            end
        end
    endtask

    initial begin
        bus.mode = 3'b000;
        bus.sin  = 1'b0;
        bus.din  = '0;
        @(negedge clk);
        test_reset;
        test_shift_right;
        test_saturation;
        test_load_rotate;
        test_shift_left;
        test_hold_reserved;
        test_reset_mid_frame;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
